// File: rtl/uart_pkg.sv
// Shared UART definitions: default character width, transmit FSM encoding and
// controller configuration field widths, reused by tx- and rx-side buffering.
package uart_pkg;

   localparam int unsigned MAX_UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_e;

   localparam int unsigned CONF_BAUD_DIV_W = 16;
   localparam int unsigned CONF_DATA_LEN_W = 2;
   localparam int unsigned CONF_PARITY_W   = 2;
   localparam int unsigned CONF_STOP_W     = 1;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer write port and controller Tx command handshake of uart_tx_buffer.
interface uart_tx_buffer_if #(
   parameter int unsigned DATA_W = 8
);

   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic              tx_busy;
   logic              tx_done;

   modport slave (
      input  wr_valid, wr_data, tx_busy, tx_done,
      output wr_ready, tx_start, tx_data
   );

   modport master (
      output wr_valid, wr_data, tx_busy, tx_done,
      input  wr_ready, tx_start, tx_data
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read data, separate level counter and a
// single-cycle flush that outranks a simultaneous push.
module uart_sync_fifo #(
   parameter  int unsigned WIDTH      = 8,
   parameter  int unsigned DEPTH      = 16,
   localparam int unsigned AddrWidth  = $clog2(DEPTH),
   localparam int unsigned LevelWidth = AddrWidth + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      push_data_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   output logic [WIDTH-1:0]      rd_data_o,
   output logic [LevelWidth-1:0] level_o,
   output logic                  empty_o,
   output logic                  full_o
);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [AddrWidth-1:0]  wr_ptr_q;
   logic [AddrWidth-1:0]  rd_ptr_q;
   logic [LevelWidth-1:0] level_q;
   logic                  do_push;
   logic                  do_pop;

   assign level_o = level_q;
   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LevelWidth'(DEPTH));
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         rd_data_o <= '0;
      end else begin
         if (do_pop) begin
            rd_data_o <= mem[rd_ptr_q];
            rd_ptr_q  <= rd_ptr_q + 1'b1;
         end
         // a pop coinciding with flush still delivers its data; the pointer reset wins
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
         end else begin
            if (do_push) begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
               2'b10:   level_q <= level_q + 1'b1;
               2'b01:   level_q <= level_q - 1'b1;
               default: level_q <= level_q;
            endcase
         end
      end
   end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit front end: buffers producer characters and launches them one at a
// time into uart_controller via tx_start/tx_busy/tx_done.
module uart_tx_buffer #(
   parameter  int unsigned MAX_UART_DATA_W = uart_pkg::MAX_UART_DATA_W,
   parameter  int unsigned FIFO_DEPTH      = 16,
   localparam int unsigned LevelWidth      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  tx_en_i,
   uart_tx_buffer_if.slave       bus,
   output logic [LevelWidth-1:0] fifo_level_o,
   output logic                  fifo_empty_o,
   output logic                  fifo_full_o,
   output logic                  idle_o
);

   import uart_pkg::*;

   tx_state_e                  state_q;
   tx_state_e                  state_d;
   logic                       hold_valid_q;
   logic                       hold_valid_d;
   logic                       pop;
   logic                       tx_start;
   logic [MAX_UART_DATA_W-1:0] fifo_rd_data;

   // The FIFO's registered read port is the holding register's data: it only
   // changes on a pop, and pops happen only while nothing is held.
   uart_sync_fifo #(
      .WIDTH (MAX_UART_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (bus.wr_valid),
      .push_data_i (bus.wr_data),
      .pop_i       (pop),
      .flush_i     (flush_i),
      .rd_data_o   (fifo_rd_data),
      .level_o     (fifo_level_o),
      .empty_o     (fifo_empty_o),
      .full_o      (fifo_full_o)
   );

   assign bus.wr_ready = !fifo_full_o;
   assign bus.tx_data  = fifo_rd_data;
   assign bus.tx_start = tx_start;
   assign idle_o       = fifo_empty_o && !hold_valid_q && (state_q == IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         hold_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      pop          = 1'b0;
      tx_start     = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_en_i && !bus.tx_busy && (hold_valid_q || !fifo_empty_o)) begin
               if (!hold_valid_q) begin
                  pop          = 1'b1;
                  hold_valid_d = 1'b1;
               end
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            tx_start = 1'b1;
            if (bus.tx_busy) begin
               state_d = WAIT_DONE;
            end else if (!tx_en_i) begin
               state_d = IDLE;
            end
         end
         WAIT_DONE: begin
            if (bus.tx_done) begin
               hold_valid_d = 1'b0;
               state_d      = IDLE;
               if (tx_en_i && !fifo_empty_o) begin
                  pop          = 1'b1;
                  hold_valid_d = 1'b1;
                  state_d      = LAUNCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed and random checks of uart_tx_buffer against a queue-based model
// and a behavioural controller that answers tx_start with busy/done.
module tb_uart_tx_buffer;

   localparam int unsigned DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       tx_en;
   logic [4:0] level;
   logic       empty;
   logic       full;
   logic       idle;

   uart_tx_buffer_if #(.DATA_W(8)) bus ();

   uart_tx_buffer #(
      .MAX_UART_DATA_W (8),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .tx_en_i      (tx_en),
      .bus          (bus.slave),
      .fifo_level_o (level),
      .fifo_empty_o (empty),
      .fifo_full_o  (full),
      .idle_o       (idle)
   );

   always #5 clk = ~clk;

   int unsigned nchk = 0;
   int unsigned nerr = 0;

   // reference state: queued characters plus the one launched but not yet done
   logic [7:0]  mq[$];
   logic        held;
   logic [7:0]  hd;
   logic        prev_start;
   int unsigned srun;

   // controller model: 0 idle, 1 start seen, 2 busy, 3 done pulse
   int unsigned ph;
   int unsigned cnt;
   int unsigned blen;
   logic        stall;
   logic        busy_m;
   logic        done_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      int unsigned size_pre;
      logic        acc;
      @(negedge clk);
      if (rst) begin
         mq.delete();
         held       = 1'b0;
         prev_start = 1'b0;
         srun       = 0;
         ph         = 0;
         cnt        = 0;
         busy_m     = 1'b0;
         done_m     = 1'b0;
      end else begin
         size_pre = mq.size();
         acc      = bus.wr_valid && (size_pre < DEPTH) && !flush;
         if (ph == 3) begin
            held = 1'b0;
            chk("b2b_start", bus.tx_start, tx_en && (size_pre > 0));
         end
         if (bus.tx_start && !prev_start && !held) begin
            chk("launch_nonempty", size_pre > 0, 1);
            if (size_pre > 0) hd = mq.pop_front();
            held = 1'b1;
         end
         if (flush) mq.delete();
         if (acc) mq.push_back(bus.wr_data);
         if (held && (bus.tx_start || ph == 2)) chk("tx_data", bus.tx_data, hd);
         if (bus.tx_start) begin
            srun++;
         end else begin
            if (srun != 0 && ph == 2) chk("start_len", srun, 3);
            srun = 0;
         end
         prev_start = bus.tx_start;
         case (ph)
            0: if (bus.tx_start) begin ph = 1; cnt = 0; end
            1: begin
               if (!bus.tx_start) begin
                  ph = 0;
               end else if (!stall) begin
                  cnt++;
                  if (cnt == 2) begin busy_m = 1'b1; ph = 2; cnt = 0; end
               end
            end
            2: begin
               cnt++;
               if (cnt == blen) begin busy_m = 1'b0; done_m = 1'b1; ph = 3; end
            end
            default: begin
               done_m = 1'b0;
               if (bus.tx_start) begin ph = 1; cnt = 0; end
               else ph = 0;
            end
         endcase
      end
      chk("level", level, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("wr_ready", bus.wr_ready, mq.size() != DEPTH);
      bus.tx_busy = busy_m;
      bus.tx_done = done_m;
   endtask

   task automatic wait_quiet(input int unsigned max);
      logic ok = 1'b0;
      for (int unsigned i = 0; i < max; i++) begin
         cyc();
         if (ph == 0 && !bus.tx_start && mq.size() == 0 && !held) begin
            ok = 1'b1;
            break;
         end
      end
      chk("quiet_timeout", ok, 1);
   endtask

   task automatic wait_busy(input int unsigned max);
      logic ok = 1'b0;
      for (int unsigned i = 0; i < max; i++) begin
         cyc();
         if (ph == 2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("busy_timeout", ok, 1);
   endtask

   task automatic push(input logic [7:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      cyc();
      bus.wr_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; tx_en = 1'b0; stall = 1'b0; blen = 20;
      bus.wr_valid = 1'b0; bus.wr_data = '0; bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
      held = 1'b0; hd = '0; prev_start = 1'b0; srun = 0;
      ph = 0; cnt = 0; busy_m = 1'b0; done_m = 1'b0;
      cyc();
      cyc();
      chk("rst_idle", idle, 1);
      chk("rst_start", bus.tx_start, 0);
      chk("rst_data", bus.tx_data, 0);
      rst = 1'b0;
      cyc();

      // single character, one-cycle head-to-start latency
      tx_en = 1'b1;
      push(8'h55);
      chk("lat_start0", bus.tx_start, 0);
      cyc();
      chk("lat_start1", bus.tx_start, 1);
      chk("lat_data", bus.tx_data, 8'h55);
      wait_quiet(60);
      chk("t1_idle", idle, 1);

      // fill to full while disabled, drop the 17th, then drain in order
      tx_en = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) push(8'(i));
      push(8'hEE);
      chk("full_flag", full, 1);
      chk("full_ready", bus.wr_ready, 0);
      chk("full_level", level, 16);
      tx_en = 1'b1;
      wait_quiet(700);

      // back-to-back launches
      tx_en = 1'b0;
      for (int unsigned i = 0; i < 3; i++) push(8'($urandom));
      tx_en = 1'b1;
      wait_quiet(150);

      // tx_en dropped in LAUNCH, then relaunch of the held character first
      stall = 1'b1;
      tx_en = 1'b0;
      push(8'hA3);
      push(8'hB1);
      tx_en = 1'b1;
      cyc();
      chk("a3_start", bus.tx_start, 1);
      cyc();
      cyc();
      tx_en = 1'b0;
      cyc();
      chk("abort_start", bus.tx_start, 0);
      chk("abort_level", level, 1);
      stall = 1'b0;
      tx_en = 1'b1;
      wait_quiet(150);

      // flush during WAIT_DONE with a simultaneous write
      tx_en = 1'b0;
      push(8'h7E);
      for (int unsigned i = 0; i < 5; i++) push(8'($urandom));
      tx_en = 1'b1;
      wait_busy(10);
      chk("pre_flush_level", level, 5);
      flush = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h11;
      cyc();
      flush = 1'b0;
      bus.wr_valid = 1'b0;
      chk("flush_level", level, 0);
      wait_quiet(60);
      chk("flush_idle", idle, 1);

      // reset in WAIT_DONE, then a stray done pulse
      push(8'($urandom));
      wait_busy(10);
      rst = 1'b1;
      cyc();
      chk("rst2_start", bus.tx_start, 0);
      chk("rst2_data", bus.tx_data, 0);
      chk("rst2_level", level, 0);
      chk("rst2_empty", empty, 1);
      chk("rst2_full", full, 0);
      chk("rst2_ready", bus.wr_ready, 1);
      chk("rst2_idle", idle, 1);
      rst = 1'b0;
      bus.tx_done = 1'b1;
      cyc();
      cyc();
      chk("stray_done_idle", idle, 1);
      chk("stray_done_start", bus.tx_start, 0);

      // random traffic with enable toggling and occasional flushes
      for (int unsigned i = 0; i < 600; i++) begin
         if (i % 150 == 0) blen = $urandom_range(2, 6);
         bus.wr_valid = 1'($urandom_range(0, 1));
         bus.wr_data  = 8'($urandom);
         tx_en        = ($urandom_range(0, 9) != 0);
         flush        = ($urandom_range(0, 49) == 0);
         cyc();
      end
      bus.wr_valid = 1'b0;
      flush = 1'b0;
      tx_en = 1'b1;
      wait_quiet(1000);
      chk("final_idle", idle, 1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Host-side transmit front end that drives the Tx command interface of uart_controller. It accepts bytes from a producer over a valid/ready write port and buffers them in a synchronous FIFO. It then feeds them one at a time into the controller using tx_start/tx_busy/tx_done handshakes, so software or a packet source can burst characters without tracking per-character completion.

Parameters:
MAX_UART_DATA_W, 8, width of one UART character; must match the controller.
FIFO_DEPTH, 16, number of buffered characters; power of two, at least 2.
LevelWidth (localparam), $clog2(FIFO_DEPTH)+1, width of the fill-level output.

Ports:
clk_i  in  1  top clock
rst_i  in  1  reset, synchronous and active-high (fixed)
wr_valid_i  in  1  producer has a character
wr_data_i  in  MAX_UART_DATA_W  character to enqueue
wr_ready_o  out  1  buffer can accept; equals !fifo_full_o
flush_i  in  1  discard all queued, un-launched characters
tx_en_i  in  1  permission to launch new characters
tx_start_o  out  1  start request to the controller's tx_start_i
tx_data_o  out  MAX_UART_DATA_W  character to the controller's tx_data_i
tx_busy_i  in  1  the controller's tx_busy_o
tx_done_i  in  1  the controller's tx_done_o (one-cycle pulse)
fifo_level_o  out  LevelWidth  queued characters (0..FIFO_DEPTH), holding register excluded
fifo_empty_o  out  1  level == 0
fifo_full_o  out  1  level == FIFO_DEPTH
idle_o  out  1  FIFO empty, holding register empty, FSM in IDLE

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - tx_start_o = 0, tx_data_o = 0, level = 0, empty = 1, full = 0, wr_ready_o = 1, idle_o = 1.
  - FSM goes to IDLE and the holding register is invalidated.
  - A reset during a character discards that character. The controller is reset by the same rst_i.
- Write side:
  - A push occurs when wr_valid_i && wr_ready_o.
  - wr_ready_o is decoded from registered state only, with no path from wr_valid_i.
  - A write while full is not accepted. There is no overflow.
- Pop and push in the same cycle (possible only when not full):
  - Level is unchanged.
  - Data written in cycle N can be popped at the earliest in cycle N+1.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Level is tracked in a separate counter.
- FSM states and transitions:
  - IDLE:
    - If a character is held, or tx_en_i && !empty && !tx_busy_i, pop the head into the holding register (pop only if nothing is held).
    - Drive tx_data_o from the holding register and go to LAUNCH.
    - Latency is one cycle from a FIFO entry becoming the head to tx_start_o = 1.
  - LAUNCH:
    - tx_start_o = 1. Hold it until tx_busy_i = 1, then go to WAIT_DONE with tx_start_o = 0 from the next cycle.
    - If tx_en_i falls before tx_busy_i rises, drop tx_start_o and return to IDLE. The character stays in the holding register and is relaunched first.
  - WAIT_DONE:
    - tx_data_o is held stable.
    - On tx_done_i, invalidate the holding register.
    - If tx_en_i && !empty, pop the next character and go to LAUNCH in the same cycle (back-to-back). Otherwise go to IDLE.
- tx_data_o is stable from entry to LAUNCH until the exit from WAIT_DONE.
- tx_done_i outside WAIT_DONE is ignored.
- flush_i:
  - Clears the FIFO pointers and level in one cycle and has priority over a simultaneous push, which is dropped.
  - It does not abort a character in LAUNCH or WAIT_DONE, and does not clear the holding register.
- A pop and a flush in the same cycle: the pop proceeds and the level becomes 0.
- tx_en_i low blocks new launches only. A character in WAIT_DONE completes.

Decomposition:
- Shared package uart_pkg: MAX_UART_DATA_W default, FSM state encoding (IDLE, LAUNCH, WAIT_DONE, 2 bits), and controller conf field widths. These are reused by rx-side buffering later.
- One sub-module uart_sync_fifo:
  - Parameterised width and depth.
  - push/pop/flush inputs, registered read data, level/empty/full outputs.
  - Rx-side buffering reuses it.
- The FSM and holding register stay in uart_tx_buffer.

Test Plan:
- Reset, then push 0x55 with tx_en_i = 1 and a model controller that raises busy 2 cycles after start and pulses done 20 cycles later -> tx_start_o high for exactly 3 cycles, tx_data_o = 0x55 throughout, idle_o = 1 after done.
- Push 16 characters 0x00..0x0F with tx_en_i = 0 -> full = 1, wr_ready_o = 0, level = 16. A 17th write is dropped. With tx_en_i = 1, characters 0x00..0x0F are launched in order and the level decrements per launch.
- Back-to-back: 3 queued characters, done pulse -> the next tx_start_o rises the cycle after tx_done_i, with no extra IDLE cycle.
- tx_en_i dropped while in LAUNCH with 0xA3 (busy never rises) -> tx_start_o falls and the level is unchanged. When tx_en_i is re-enabled, 0xA3 is relaunched before later characters.
- flush_i with level = 5 during WAIT_DONE on 0x7E, with a simultaneous write of 0x11 -> level = 0, 0x11 is lost, 0x7E completes, idle_o = 1 after done.
- Reset asserted in WAIT_DONE -> all outputs reach their reset values the next cycle. A tx_done_i pulse afterwards has no effect.
